// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the execute-stage blocks:
// M-extension funct3 codes, opcode/funct7 for R-type M ops and the
// multiply/divide FSM state type.
package riscv_pkg;

    localparam logic [6:0] OP_RTYPE   = 7'b0110011;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam logic [2:0] F3_MUL     = 3'b000;
    localparam logic [2:0] F3_MULH    = 3'b001;
    localparam logic [2:0] F3_MULHSU  = 3'b010;
    localparam logic [2:0] F3_MULHU   = 3'b011;
    localparam logic [2:0] F3_DIV     = 3'b100;
    localparam logic [2:0] F3_DIVU    = 3'b101;
    localparam logic [2:0] F3_REM     = 3'b110;
    localparam logic [2:0] F3_REMU    = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_e.sv
// Iterative radix-2 RV32M multiply/divide unit in the execute stage.
// Operands are reduced to magnitudes at start, one product/quotient bit is
// produced per BUSY cycle in a shared hi/lo register pair, and the sign
// fix-up is applied combinationally while the result is presented in DONE.
module muldiv_e
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int FUNCT3_WIDTH = 3,
    parameter int CNT_WIDTH    = 6
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    CLR,
    input  logic                    StartE,
    input  logic [FUNCT3_WIDTH-1:0] funct3E,
    input  logic [DATA_WIDTH-1:0]   SrcAE,
    input  logic [DATA_WIDTH-1:0]   SrcBE,
    output logic                    BusyE,
    output logic                    DoneE,
    output logic [DATA_WIDTH-1:0]   ResultE
);

    localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

    muldiv_state_t           state;
    logic [CNT_WIDTH-1:0]    count;
    logic [FUNCT3_WIDTH-1:0] op_q;
    logic                    sign_a_q;
    logic                    sign_b_q;
    logic                    special_q;
    logic [DATA_WIDTH-1:0]   opnd_q;   // multiplicand (MUL*) or divisor (DIV/REM) magnitude
    logic [DATA_WIDTH-1:0]   hi_q;     // product high half / partial remainder
    logic [DATA_WIDTH-1:0]   lo_q;     // multiplier->product low half / dividend->quotient

    // Start-cycle decode of the incoming operation.
    logic                  is_div;
    logic                  a_signed;
    logic                  b_signed;
    logic                  sa;
    logic                  sb;
    logic [DATA_WIDTH-1:0] a_mag;
    logic [DATA_WIDTH-1:0] b_mag;
    logic                  div_zero;
    logic                  div_ovf;

    // Classify the op in E and reduce its operands to magnitudes.
    always_comb begin
        is_div   = funct3E[2];
        a_signed = (funct3E != F3_MULHU) && (funct3E != F3_DIVU) && (funct3E != F3_REMU);
        b_signed = a_signed && (funct3E != F3_MULHSU);
        sa       = a_signed && SrcAE[DATA_WIDTH-1];
        sb       = b_signed && SrcBE[DATA_WIDTH-1];
        a_mag    = sa ? (~SrcAE + 1'b1) : SrcAE;
        b_mag    = sb ? (~SrcBE + 1'b1) : SrcBE;
        div_zero = is_div && (SrcBE == '0);
        div_ovf  = is_div && b_signed && (SrcAE == MIN_NEG) && (SrcBE == ALL_ONES);
    end

    // One iteration step of the shared datapath.
    logic [DATA_WIDTH:0]   mul_sum;
    logic [DATA_WIDTH:0]   div_shift;
    logic [DATA_WIDTH:0]   div_diff;
    logic [DATA_WIDTH-1:0] hi_step;
    logic [DATA_WIDTH-1:0] lo_step;

    // Shift-add for multiply, restoring subtract for divide.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        hi_step   = hi_q;
        lo_step   = lo_q;
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {hi_q, lo_q[DATA_WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (op_q[2]) begin
            if (!div_diff[DATA_WIDTH]) begin
                hi_step = div_diff[DATA_WIDTH-1:0];
                lo_step = {lo_q[DATA_WIDTH-2:0], 1'b1};
            end else begin
                hi_step = div_shift[DATA_WIDTH-1:0];
                lo_step = {lo_q[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_step = mul_sum[DATA_WIDTH:1];
            lo_step = {mul_sum[0], lo_q[DATA_WIDTH-1:1]};
        end
    end

    // FSM, iteration counter and datapath registers.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the datapath registers are reset too, so no stale operand can ever reach ResultE after reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= MD_IDLE;
            count     <= '0;
            op_q      <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            special_q <= 1'b0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else if (CLR) begin
            state <= MD_IDLE;
            count <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (StartE) begin
                        state     <= MD_BUSY;
                        count     <= '0;
                        op_q      <= funct3E;
                        sign_a_q  <= sa;
                        sign_b_q  <= sb;
                        special_q <= div_zero || div_ovf;
                        if (div_zero) begin
                            opnd_q <= '0;
                            hi_q   <= SrcAE;
                            lo_q   <= ALL_ONES;
                        end else if (div_ovf) begin
                            opnd_q <= '0;
                            hi_q   <= '0;
                            lo_q   <= MIN_NEG;
                        end else if (is_div) begin
                            opnd_q <= b_mag;
                            hi_q   <= '0;
                            lo_q   <= a_mag;
                        end else begin
                            opnd_q <= a_mag;
                            hi_q   <= '0;
                            lo_q   <= b_mag;
                        end
                    end
                end
                MD_BUSY: begin
                    if (special_q) begin
                        state <= MD_DONE;
                    end else begin
                        hi_q  <= hi_step;
                        lo_q  <= lo_step;
                        count <= count + CNT_WIDTH'(1);
                        if (count == LAST_CNT) begin
                            state <= MD_DONE;
                        end
                    end
                end
                MD_DONE: begin
                    state <= MD_IDLE;
                    count <= '0;
                end
                default: begin
                    state <= MD_IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    // Sign fix-up and result selection, visible only in DONE.
    logic [2*DATA_WIDTH-1:0] prod;
    logic [2*DATA_WIDTH-1:0] prod_fix;
    logic [DATA_WIDTH-1:0]   quo_fix;
    logic [DATA_WIDTH-1:0]   rem_fix;
    logic [DATA_WIDTH-1:0]   result;

    // Apply signs to the magnitudes and pick the half/quantity the op returns.
    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = (sign_a_q ^ sign_b_q) ? (~prod + 1'b1) : prod;
        quo_fix  = special_q ? lo_q : ((sign_a_q ^ sign_b_q) ? (~lo_q + 1'b1) : lo_q);
        rem_fix  = special_q ? hi_q : (sign_a_q ? (~hi_q + 1'b1) : hi_q);
        case (op_q)
            F3_MUL:                        result = prod_fix[DATA_WIDTH-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  result = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
            F3_DIV, F3_DIVU:               result = quo_fix;
            default:                       result = rem_fix;
        endcase
    end

    // Stall request is combinational on StartE in IDLE so the start cycle already stalls.
    always_comb begin
        BusyE   = (state == MD_IDLE) ? StartE : (state == MD_BUSY);
        DoneE   = (state == MD_DONE);
        ResultE = DoneE ? result : '0;
    end

endmodule

// File: tb/tb_muldiv_e.sv
// Self-checking bench for muldiv_e: directed RV32M corner cases plus
// randomized operations against an arithmetic reference model, with
// latency, back-to-back, flush and reset-abort scenarios.
module tb_muldiv_e;

    logic        CLK;
    logic        RST_N;
    logic        CLR;
    logic        StartE;
    logic [2:0]  funct3E;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        BusyE;
    logic        DoneE;
    logic [31:0] ResultE;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_e #(.DATA_WIDTH(32), .FUNCT3_WIDTH(3), .CNT_WIDTH(6)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .CLR     (CLR),
        .StartE  (StartE),
        .funct3E (funct3E),
        .SrcAE   (SrcAE),
        .SrcBE   (SrcBE),
        .BusyE   (BusyE),
        .DoneE   (DoneE),
        .ResultE (ResultE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference result straight from the RV32M definitions.
    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     pv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f3)
            3'd0: begin pv = sa * sb;          return pv[31:0];  end
            3'd1: begin pv = sa * sb;          return pv[63:32]; end
            3'd2: begin pv = sa * longint'(ub); return pv[63:32]; end
            3'd3: begin pv = ua * ub;          return pv[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                pv = sa / sb; return pv[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                pv = ua / ub; return pv[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                pv = sa % sb; return pv[31:0];
            end
            default: begin
                if (b == 0) return a;
                pv = ua % ub; return pv[31:0];
            end
        endcase
    endfunction

    // Cycle index (C0 = 0) at which DoneE is expected.
    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3 >= 3'd4 && b == 0) return 2;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 9))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Drive the start cycle C0; leaves time at negedge+1 of C0.
    task automatic begin_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        StartE  = 1'b1;
        funct3E = f3;
        SrcAE   = a;
        SrcBE   = b;
        #1;
    endtask

    // From C0, wait (bounded) for DoneE and check latency, busy length and result.
    task automatic finish_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input bit hold);
        int idx;
        int busy_n;
        bit seen;
        int lat;
        logic [31:0] exp;
        exp    = ref_md(f3, a, b);
        lat    = ref_lat(f3, a, b);
        idx    = 0;
        busy_n = 0;
        seen   = 1'b0;
        while (idx < 100) begin
            if (DoneE) begin
                seen = 1'b1;
                break;
            end
            if (BusyE) busy_n++;
            @(negedge CLK);
            if (!hold) StartE = 1'b0;
            #1;
            idx++;
        end
        check({tag, " done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            check({tag, " done_cycle"}, 64'(idx), 64'(lat));
            check({tag, " busy_cycles"}, 64'(busy_n), 64'(lat));
            check({tag, " result"}, 64'(ResultE), 64'(exp));
            check({tag, " busy_in_done"}, 64'(BusyE), 64'd0);
        end
    endtask

    // Return to idle after DONE and confirm outputs drop.
    task automatic idle_after(input string tag);
        @(negedge CLK);
        StartE = 1'b0;
        #1;
        check({tag, " done_clear"}, 64'(DoneE), 64'd0);
        check({tag, " result_clear"}, 64'(ResultE), 64'd0);
    endtask

    task automatic full_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        begin_op(f3, a, b);
        check({tag, " busy_c0"}, 64'(BusyE), 64'd1);
        finish_op(tag, f3, a, b, 1'b0);
        idle_after(tag);
    endtask

    initial begin
        bit seen;
        RST_N   = 1'b0;
        CLR     = 1'b0;
        StartE  = 1'b0;
        funct3E = 3'd0;
        SrcAE   = '0;
        SrcBE   = '0;
        #2;
        check("reset busy", 64'(BusyE), 64'd0);
        check("reset done", 64'(DoneE), 64'd0);
        check("reset result", 64'(ResultE), 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        // Directed cases.
        full_op("mul 7x-3",        3'd0, 32'd7,          32'hFFFF_FFFD);
        full_op("mulh min*min",    3'd1, 32'h8000_0000,  32'h8000_0000);
        full_op("mulhu ff*ff",     3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
        full_op("mulhsu -1*ff",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
        full_op("div -7/2",        3'd4, 32'hFFFF_FFF9,  32'd2);
        full_op("rem -7/2",        3'd6, 32'hFFFF_FFF9,  32'd2);
        full_op("divu 100/7",      3'd5, 32'd100,        32'd7);
        full_op("remu 100/7",      3'd7, 32'd100,        32'd7);
        full_op("div 5/0",         3'd4, 32'd5,          32'd0);
        full_op("rem 5/0",         3'd6, 32'd5,          32'd0);
        full_op("div min/-1",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF);
        full_op("rem min/-1",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF);

        // Back-to-back: StartE held through DONE, second op starts the cycle after.
        begin_op(3'd0, 32'd12345, 32'd678);
        finish_op("b2b first", 3'd0, 32'd12345, 32'd678, 1'b1);
        @(negedge CLK);
        funct3E = 3'd5;
        SrcAE   = 32'd1000;
        SrcBE   = 32'd9;
        #1;
        check("b2b second c0 busy", 64'(BusyE), 64'd1);
        check("b2b second c0 done", 64'(DoneE), 64'd0);
        finish_op("b2b second", 3'd5, 32'd1000, 32'd9, 1'b0);
        idle_after("b2b second");

        // Flush at BUSY cycle 10: back to idle, no completion.
        begin_op(3'd5, 32'd1000, 32'd3);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            StartE = 1'b0;
            #1;
        end
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        #1;
        check("clr busy", 64'(BusyE), 64'd0);
        check("clr done", 64'(DoneE), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            #1;
            if (DoneE || BusyE) seen = 1'b1;
        end
        check("clr no activity", 64'(seen), 64'd0);
        full_op("after clr", 3'd6, 32'hFFFF_FF00, 32'd7);

        // Reset mid-BUSY: stall released immediately.
        begin_op(3'd1, 32'hDEAD_BEEF, 32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            StartE = 1'b0;
            #1;
        end
        check("pre-reset busy", 64'(BusyE), 64'd1);
        RST_N = 1'b0;
        #1;
        check("rst busy busy", 64'(BusyE), 64'd0);
        check("rst busy done", 64'(DoneE), 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Reset while the result is presented: result vanishes at once.
        begin_op(3'd0, 32'd7, 32'hFFFF_FFFD);
        finish_op("pre-reset op", 3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
        RST_N = 1'b0;
        #1;
        check("rst done busy", 64'(BusyE), 64'd0);
        check("rst done done", 64'(DoneE), 64'd0);
        check("rst done result", 64'(ResultE), 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check("post-reset done", 64'(DoneE), 64'd0);

        // Randomized operations against the reference model.
        for (int n = 0; n < 60; n++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] b;
            f3 = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            full_op($sformatf("rand%0d f3=%0d a=%h b=%h", n, f3, a, b), f3, a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
